// File: rtl/gpr_file_mp_pkg.sv
// gpr_file_mp_pkg
//   Shared constants for the MIPS general-purpose register file:
//   default geometry (address/data width, read/write port counts) and the
//   clear-engine state encoding. The register file and its clear FSM both import it.
package gpr_file_mp_pkg;

  localparam int GPR_ADDR_W   = 5;
  localparam int GPR_DATA_W   = 32;
  localparam int GPR_RD_PORTS = 2;
  localparam int GPR_WR_PORTS = 2;

  // CLEAR: the engine is zeroing the array and the file is unusable.
  // READY: normal operation.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage : gpr_file_mp_pkg

// File: rtl/gpr_file_mp_clear_fsm.sv
// regfile_clear_fsm
//   Post-reset clear engine for the register file. After rst falls it walks
//   clr_ptr over every entry, one entry per cycle, and then enters READY.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous reset, active-high; restarts the clear at entry 0
//     busy     out  1 while in CLEAR (including while rst is held)
//     clr_we   out  1 when the array must zero entry clr_addr on this edge
//     clr_addr out  entry being cleared
module regfile_clear_fsm
  import gpr_file_mp_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RF_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Next-state logic. The pointer wraps back to 0 on the last entry, so it
  // is already at 0 should a later reset re-enter CLEAR.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == RF_CLEAR) begin
      clr_ptr_next = clr_ptr_reg + 1'b1;
      if (&clr_ptr_reg) begin
        state_next = RF_READY;
      end
    end
  end

  // Outputs. No entry is cleared while rst is held; clearing starts on the
  // first edge after release.
  always_comb begin
    busy     = (state_reg == RF_CLEAR);
    clr_we   = (state_reg == RF_CLEAR) && !rst;
    clr_addr = clr_ptr_reg;
  end

endmodule : regfile_clear_fsm

// File: rtl/gpr_file_mp.sv
// gpr_file_mp
//   Multi-port general-purpose register file for the 5-stage MIPS core.
//   NUM_RD combinational read ports, NUM_WR synchronous write ports, an
//   optional write-to-read bypass and an optional hardwired zero register.
//   The array is zeroed by a clear engine after every reset.
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   synchronous reset, active-high
//     rd_addr     in   read addresses, port k at [k*ADDR_W +: ADDR_W]
//     rd_data     out  read data,      port k at [k*DATA_W +: DATA_W]
//     wr_en       in   per-port write enable
//     wr_addr     in   write addresses, port j at [j*ADDR_W +: ADDR_W]
//     wr_data     in   write data,      port j at [j*DATA_W +: DATA_W]
//     busy        out  1 during reset and clearing; writes ignored, reads return 0
//     wr_conflict out  1 the cycle after two kept writes hit the same address
module gpr_file_mp
  import gpr_file_mp_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int NUM_RD   = GPR_RD_PORTS,
  parameter int NUM_WR   = GPR_WR_PORTS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [NUM_WR-1:0] wr_keep;
  logic              wr_conflict_reg, wr_conflict_next;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes only land in READY and outside reset.
  assign wr_ok = !busy && !rst;

  // A write is kept when enabled, allowed, and not aimed at the zero register.
  // Dropped writes neither update the array, bypass, nor count as conflicts.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_keep
    assign wr_keep[gi] = wr_ok && wr_en[gi] &&
                         !((ZERO_REG != 0) && (wr_addr[gi*ADDR_W +: ADDR_W] == '0));
  end

  // Array update. Ports are applied in ascending order so the last
  // non-blocking assignment, from the highest-index port, wins a collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_reg[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_keep[i]) begin
          mem_reg[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports. The busy mask also hides the uninitialised array before the
  // first clear completes.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem_reg[ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_keep[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ra)) begin
            rv = wr_data[i*DATA_W +: DATA_W];
          end
        end
      end
      if (busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rv = '0;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rv;
  end

  // Any pair of kept writes sharing an address is a conflict.
  always_comb begin
    wr_conflict_next = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_keep[i] && wr_keep[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          wr_conflict_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict_reg <= 1'b0;
    end else begin
      wr_conflict_reg <= wr_conflict_next;
    end
  end

  assign wr_conflict = wr_conflict_reg;

endmodule : gpr_file_mp
